// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer for the RV32 EX stage.
// Handles CSR read-modify-write, MRET, WFI, interrupts and the 64-bit counters.
module csr_unit #(
    parameter logic [31:0] MTVEC = 32'h0001_0000,
    parameter int          XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [31:0]     ex_pc,
    input  logic            csr_valid,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      csr_rs1_idx,
    input  logic [XLEN-1:0] csr_rs1_data,
    input  logic            mret_valid,
    input  logic            wfi_valid,
    input  logic            retire,
    input  logic            ext_irq,
    input  logic            timer_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic            wfi_stall
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_WFI_WAIT = 1'b1;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    logic [0:0]      state_reg;
    logic            mstatus_mie_reg;
    logic            mstatus_mpie_reg;
    logic            mie_meie_reg;
    logic            mie_mtie_reg;
    logic [31:0]     mepc_reg;
    logic [31:0]     wfi_pc_reg;
    logic [63:0]     mcycle_reg;
    logic [63:0]     minstret_reg;
    logic            redirect_valid_reg;
    logic [31:0]     redirect_pc_reg;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mie_val;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] csr_src;
    logic [XLEN-1:0] csr_wdata;
    logic [63:0]     mcycle_next;
    logic [63:0]     minstret_next;
    logic            irq_pend;
    logic            ex_live;
    logic            in_run;
    logic            csr_wr_req;
    logic            csr_we;
    logic            trap_run;
    logic            trap_wake;
    logic            trap_any;
    logic            do_mret;
    logic            do_wfi;
    logic            wake;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mstatus_mpie_reg;
        mstatus_val[3]     = mstatus_mie_reg;
        mie_val            = '0;
        mie_val[11]        = mie_meie_reg;
        mie_val[7]         = mie_mtie_reg;
        mip_val            = '0;
        mip_val[11]        = ext_irq;
        mip_val[7]         = timer_irq;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS:               csr_rdata = mstatus_val;
            A_MIE:                   csr_rdata = mie_val;
            A_MTVEC:                 csr_rdata = MTVEC;
            A_MEPC:                  csr_rdata = mepc_reg;
            A_MIP:                   csr_rdata = mip_val;
            A_MCYCLE,   A_CYCLE:     csr_rdata = mcycle_reg[31:0];
            A_MCYCLEH,  A_CYCLEH:    csr_rdata = mcycle_reg[63:32];
            A_MINSTRET, A_INSTRET:   csr_rdata = minstret_reg[31:0];
            A_MINSTRETH, A_INSTRETH: csr_rdata = minstret_reg[63:32];
            default:                 csr_rdata = '0;
        endcase
    end

    assign irq_pend = (mie_meie_reg & ext_irq) | (mie_mtie_reg & timer_irq);

    // The instruction in EX during a redirect pulse is being flushed, so it never fires a second event.
    assign ex_live = ex_valid & ~redirect_valid_reg & ~stall;
    assign in_run  = (state_reg == ST_RUN);

    assign csr_src = csr_funct3[2] ? {{(XLEN-5){1'b0}}, csr_rs1_idx} : csr_rs1_data;

    always_comb begin
        csr_wdata = csr_src;
        case (csr_funct3[1:0])
            2'b10:   csr_wdata = csr_rdata | csr_src;
            2'b11:   csr_wdata = csr_rdata & ~csr_src;
            default: csr_wdata = csr_src;
        endcase
    end

    // Set/clear forms with a zero operand are pure reads.
    assign csr_wr_req = csr_valid & ex_live & in_run & (csr_funct3[1:0] != 2'b00)
                      & ~(csr_funct3[1] & (csr_rs1_idx == 5'd0));

    assign trap_run  = in_run & mstatus_mie_reg & irq_pend & ex_live;
    assign do_mret   = in_run & ~trap_run & mret_valid & ex_live;
    assign do_wfi    = in_run & ~trap_run & ~do_mret & wfi_valid & ex_live;
    assign wake      = ~in_run & irq_pend;
    assign trap_wake = wake & mstatus_mie_reg;
    assign trap_any  = trap_run | trap_wake;
    assign csr_we    = csr_wr_req & ~trap_run;

    always_comb begin
        mcycle_next   = mcycle_reg + 64'd1;
        minstret_next = minstret_reg + {63'd0, retire};
        if (csr_we && csr_addr == A_MCYCLE)
            mcycle_next = {mcycle_reg[63:32], csr_wdata};
        else if (csr_we && csr_addr == A_MCYCLEH)
            mcycle_next = {csr_wdata, mcycle_reg[31:0]};
        if (csr_we && csr_addr == A_MINSTRET)
            minstret_next = {minstret_reg[63:32], csr_wdata};
        else if (csr_we && csr_addr == A_MINSTRETH)
            minstret_next = {csr_wdata, minstret_reg[31:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= ST_RUN;
            mstatus_mie_reg    <= 1'b0;
            mstatus_mpie_reg   <= 1'b0;
            mie_meie_reg       <= 1'b0;
            mie_mtie_reg       <= 1'b0;
            mepc_reg           <= '0;
            wfi_pc_reg         <= '0;
            mcycle_reg         <= '0;
            minstret_reg       <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;

            if (trap_any) begin
                mstatus_mpie_reg <= mstatus_mie_reg;
                mstatus_mie_reg  <= 1'b0;
            end else if (do_mret) begin
                mstatus_mie_reg  <= mstatus_mpie_reg;
                mstatus_mpie_reg <= 1'b1;
            end else if (csr_we && csr_addr == A_MSTATUS) begin
                mstatus_mie_reg  <= csr_wdata[3];
                mstatus_mpie_reg <= csr_wdata[7];
            end

            if (csr_we && csr_addr == A_MIE) begin
                mie_meie_reg <= csr_wdata[11];
                mie_mtie_reg <= csr_wdata[7];
            end

            if (trap_run)
                mepc_reg <= {ex_pc[31:2], 2'b00};
            else if (trap_wake)
                mepc_reg <= wfi_pc_reg;
            else if (csr_we && csr_addr == A_MEPC)
                mepc_reg <= {csr_wdata[31:2], 2'b00};

            if (do_wfi) begin
                wfi_pc_reg <= ex_pc + 32'd4;
                state_reg  <= ST_WFI_WAIT;
            end else if (wake) begin
                state_reg  <= ST_RUN;
            end

            redirect_valid_reg <= trap_any | do_mret | wake;
            if (trap_any)
                redirect_pc_reg <= MTVEC;
            else if (do_mret)
                redirect_pc_reg <= mepc_reg;
            else if (wake)
                redirect_pc_reg <= wfi_pc_reg;
        end
    end

    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign wfi_stall      = (state_reg == ST_WFI_WAIT);

endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit: CSR ops, traps, MRET, WFI, counters and async reset.
module tb_csr_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        csr_valid;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rs1_idx;
    logic [31:0] csr_rs1_data;
    logic        mret_valid;
    logic        wfi_valid;
    logic        retire;
    logic        ext_irq;
    logic        timer_irq;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wfi_stall;

    int total_cnt = 0;
    int bad_cnt   = 0;

    csr_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .csr_valid(csr_valid), .csr_funct3(csr_funct3), .csr_addr(csr_addr),
        .csr_rs1_idx(csr_rs1_idx), .csr_rs1_data(csr_rs1_data),
        .mret_valid(mret_valid), .wfi_valid(wfi_valid), .retire(retire),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .wfi_stall(wfi_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        csr_valid  = 1'b0;
        mret_valid = 1'b0;
        wfi_valid  = 1'b0;
        ex_valid   = 1'b0;
        stall      = 1'b0;
        retire     = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
        csr_valid = 1'b0;
        csr_addr  = a;
        #1;
        chk(tag, csr_rdata, e);
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a,
                          input logic [4:0] idx, input logic [31:0] data);
        csr_valid    = 1'b1;
        ex_valid     = 1'b1;
        csr_funct3   = f3;
        csr_addr     = a;
        csr_rs1_idx  = idx;
        csr_rs1_data = data;
        #1;
    endtask

    // One-cycle CSR instruction, then drop it from EX.
    task automatic csr_do(input logic [2:0] f3, input logic [11:0] a,
                          input logic [4:0] idx, input logic [31:0] data);
        csr_op(f3, a, idx, data);
        tick;
        clr;
    endtask

    initial begin
        rst_n = 1'b0;
        clr;
        ex_pc = 32'h0; csr_funct3 = 3'b000; csr_addr = 12'h000;
        csr_rs1_idx = 5'd0; csr_rs1_data = 32'h0; ext_irq = 1'b0; timer_irq = 1'b0;
        #2;
        chk("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'h0);
        chk("rst wfi_stall", {31'd0, wfi_stall}, 32'd0);
        rd(12'h300, 32'h0000_1800, "rst mstatus");
        rd(12'h304, 32'h0, "rst mie");
        rd(12'h305, 32'h0001_0000, "mtvec");
        #10;
        rst_n = 1'b1;
        tick;

        // CSRRW mepc with misaligned source
        csr_op(3'b001, 12'h341, 5'd2, 32'h0000_1237);
        chk("csrrw mepc old", csr_rdata, 32'h0);
        tick; clr;
        rd(12'h341, 32'h0000_1234, "mepc after rw");

        // CSRRS x0 is a pure read; CSRRSI sets MIE
        csr_op(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF);
        chk("csrrs x0 mstatus old", csr_rdata, 32'h0000_1800);
        tick; clr;
        rd(12'h300, 32'h0000_1800, "mstatus no write");
        csr_do(3'b110, 12'h300, 5'd8, 32'h0);
        rd(12'h300, 32'h0000_1808, "mstatus csrrsi");

        // mie writable mask, then CSRRC to leave only MTIE
        csr_do(3'b001, 12'h304, 5'd3, 32'hFFFF_FFFF);
        rd(12'h304, 32'h0000_0880, "mie mask");
        csr_do(3'b011, 12'h304, 5'd4, 32'h0000_0800);
        rd(12'h304, 32'h0000_0080, "mie csrrc");

        // Unmapped and read-only writes are ignored
        csr_do(3'b001, 12'h7C0, 5'd1, 32'hDEAD_BEEF);
        rd(12'h7C0, 32'h0, "unmapped read");
        csr_do(3'b001, 12'h305, 5'd1, 32'h0);
        rd(12'h305, 32'h0001_0000, "mtvec ro");

        // Timer trap: blocked while stalled, taken once stall drops
        timer_irq = 1'b1;
        ex_valid = 1'b1; ex_pc = 32'h200; stall = 1'b1;
        rd(12'h344, 32'h0000_0080, "mip timer");
        tick;
        chk("stalled no redirect", {31'd0, redirect_valid}, 32'd0);
        stall = 1'b0;
        tick;
        clr; timer_irq = 1'b0;
        chk("trap redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("trap redirect_pc", redirect_pc, 32'h0001_0000);
        rd(12'h341, 32'h0000_0200, "trap mepc");
        rd(12'h300, 32'h0000_1880, "trap mstatus");
        tick;
        chk("trap pulse ends", {31'd0, redirect_valid}, 32'd0);

        // MRET
        mret_valid = 1'b1; ex_valid = 1'b1; ex_pc = 32'h0001_0004;
        tick; clr;
        chk("mret redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("mret redirect_pc", redirect_pc, 32'h0000_0200);
        rd(12'h300, 32'h0000_1888, "mret mstatus");
        tick;
        chk("mret pulse ends", {31'd0, redirect_valid}, 32'd0);

        // WFI with MIE=1, woken by external interrupt -> trap
        csr_do(3'b001, 12'h304, 5'd5, 32'h0000_0800);
        wfi_valid = 1'b1; ex_valid = 1'b1; ex_pc = 32'h300;
        tick; clr;
        for (int i = 0; i < 5; i++) begin
            timer_irq = (i == 2);
            stall = (i == 3);
            #1;
            chk($sformatf("wfi wait %0d stall", i), {31'd0, wfi_stall}, 32'd1);
            chk($sformatf("wfi wait %0d redirect", i), {31'd0, redirect_valid}, 32'd0);
            tick;
        end
        timer_irq = 1'b0; stall = 1'b0;
        ext_irq = 1'b1;
        tick;
        ext_irq = 1'b0;
        chk("wake1 wfi_stall", {31'd0, wfi_stall}, 32'd0);
        chk("wake1 redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("wake1 redirect_pc", redirect_pc, 32'h0001_0000);
        rd(12'h341, 32'h0000_0304, "wake1 mepc");
        rd(12'h300, 32'h0000_1880, "wake1 mstatus");
        tick;
        chk("wake1 pulse ends", {31'd0, redirect_valid}, 32'd0);

        // WFI with MIE=0: resume after the WFI, no trap
        wfi_valid = 1'b1; ex_valid = 1'b1; ex_pc = 32'h500;
        tick; clr;
        tick; tick;
        chk("wfi2 stall", {31'd0, wfi_stall}, 32'd1);
        ext_irq = 1'b1;
        tick;
        ext_irq = 1'b0;
        chk("wake2 wfi_stall", {31'd0, wfi_stall}, 32'd0);
        chk("wake2 redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("wake2 redirect_pc", redirect_pc, 32'h0000_0504);
        rd(12'h341, 32'h0000_0304, "wake2 mepc kept");
        rd(12'h300, 32'h0000_1880, "wake2 mstatus kept");
        tick;

        // mcycle: write both halves, then wrap to zero two cycles later
        csr_do(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFE);
        csr_op(3'b001, 12'hB80, 5'd1, 32'hFFFF_FFFF);
        tick; clr;
        rd(12'hB00, 32'hFFFF_FFFE, "mcycle lo held");
        rd(12'hB80, 32'hFFFF_FFFF, "mcycleh written");
        tick; tick;
        rd(12'hB00, 32'h0, "mcycle wrap lo");
        rd(12'hB80, 32'h0, "mcycleh wrap hi");
        rd(12'hC00, 32'h0, "cycle shadow");
        tick;
        rd(12'hC00, 32'h1, "cycle after wrap");

        // minstret: three retires, then write wins over retire
        rd(12'hB02, 32'h0, "minstret start");
        retire = 1'b1;
        tick; tick; tick;
        retire = 1'b0;
        rd(12'hB02, 32'h3, "minstret +3");
        rd(12'hC02, 32'h3, "instret shadow");
        rd(12'hB82, 32'h0, "minstreth");
        csr_op(3'b001, 12'hB02, 5'd1, 32'h0000_0010);
        retire = 1'b1;
        tick; clr;
        rd(12'hB02, 32'h0000_0010, "minstret write over retire");

        // Async reset while waiting in WFI
        wfi_valid = 1'b1; ex_valid = 1'b1; ex_pc = 32'h600;
        tick; clr;
        chk("wfi3 stall", {31'd0, wfi_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst wfi_stall", {31'd0, wfi_stall}, 32'd0);
        chk("async rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("async rst redirect_pc", redirect_pc, 32'h0);
        rd(12'h300, 32'h0000_1800, "async rst mstatus");
        rd(12'h341, 32'h0, "async rst mepc");
        #3;
        rst_n = 1'b1;
        tick;
        chk("post rst run", {31'd0, wfi_stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR file and trap sequencer for the 5-stage RV32 core.
- Sits in EX and consumes the decoder's isCSR/isMRET/isWFI qualified instruction stream.
- Executes CSR read-modify-write, MRET and WFI, takes external and timer interrupts, and drives pipeline redirect and stall.
- Keeps the 64-bit cycle and instret counters.

Parameters:
MTVEC, 32'h0001_0000, fixed trap vector; read-only mtvec value
XLEN, 32, data width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  pipeline stall; EX instruction does not advance
ex_valid  input  1  EX holds a live (not flushed) instruction
ex_pc  input  32  PC of EX instruction
csr_valid  input  1  EX instruction is CSRRW/S/C[I]
csr_funct3  input  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
csr_addr  input  12  CSR address
csr_rs1_idx  input  5  rs1 index; also the zimm operand
csr_rs1_data  input  32  forwarded rs1 value
mret_valid  input  1  EX instruction is MRET
wfi_valid  input  1  EX instruction is WFI
retire  input  1  one instruction retired in WB this cycle
ext_irq  input  1  level external interrupt (MEIP)
timer_irq  input  1  level timer interrupt (MTIP)
csr_rdata  output  32  old CSR value, written to rd
redirect_valid  output  1  flush and fetch from redirect_pc
redirect_pc  output  32  redirect target
wfi_stall  output  1  freeze fetch/decode while waiting

Behaviour:
- Reset (async, rst_n=0) values:
  - mstatus=32'h0000_1800 (MIE bit3=0, MPIE bit7=0, MPP[12:11]=11 hardwired).
  - mie=0, mepc=0, mcycle=0, minstret=0.
  - state=RUN; redirect_valid=0, redirect_pc=0, wfi_stall=0.
- CSR map:
  - mstatus 300, mie 304 (only bits 11, 7 writable), mtvec 305 (RO=MTVEC), mepc 341 (bits[1:0] forced 0), mip 344 (RO, bit11=ext_irq, bit7=timer_irq).
  - mcycle B00/mcycleh B80, minstret B02/minstreth B82.
  - Read-only shadows C00/C80/C02/C82.
  - Unmapped addresses read 0; writes to them are ignored.
- csr_rdata is combinational: the current value of csr_addr.
- Write source: src = funct3[2] ? {27'b0, csr_rs1_idx} : csr_rs1_data.
  - RW writes src; RS writes old|src; RC writes old&~src.
  - RS/RC/RSI/RCI with csr_rs1_idx==0 perform no write.
- Write commits at the clock edge when csr_valid & ex_valid & ~stall and no trap is taken that cycle.
- Counters:
  - mcycle +1 every cycle; minstret +1 when retire.
  - Both are 64-bit and wrap from FFFF_FFFF_FFFF_FFFF to 0.
  - A CSR write to a half replaces that half in that cycle; the increment is dropped that cycle for that counter.
- irq_pend = |(mie & mip) over bits 11 and 7.
- RUN state, priority highest first:
  - Trap: mstatus.MIE & irq_pend & ex_valid & ~stall.
    - mepc<=ex_pc; EX instruction squashed (no CSR write).
    - MPIE<=MIE, MIE<=0.
    - Next cycle redirect_valid=1, redirect_pc=MTVEC.
  - MRET: mret_valid & ex_valid & ~stall.
    - MIE<=MPIE, MPIE<=1.
    - Next cycle redirect_valid=1, redirect_pc=mepc (value before this edge).
  - WFI: wfi_valid & ex_valid & ~stall.
    - wfi_pc<=ex_pc+4; go WFI_WAIT.
    - wfi_stall=1 from the next cycle.
- WFI_WAIT state:
  - wfi_stall=1; the stall input is ignored.
  - When irq_pend=1, return to RUN. Next cycle wfi_stall=0, redirect_valid=1, and:
    - If MIE=1: take the trap (mepc<=wfi_pc, MPIE<=MIE, MIE<=0), redirect_pc=MTVEC.
    - If MIE=0: redirect_pc=wfi_pc; no CSR change.
- Redirect timing: redirect_valid is a registered single-cycle pulse, exactly 1 cycle after the event. It never asserts two consecutive cycles.
- The pipeline flushes EX on redirect_valid, so no second event fires from the same instruction.
- Reset mid-WFI_WAIT returns to RUN with all outputs 0.
- irq inputs are level, not latched; deassertion before sampling means no trap.

Test Plan:
- CSRRW x1, mepc, x2 (x2=32'h0000_1237) -> csr_rdata=0 that cycle; next read of mepc=32'h0000_1234.
- CSRRS with rs1_idx=0 on mstatus -> csr_rdata=32'h0000_1800, no write. CSRRSI zimm=8 -> mstatus=32'h0000_1808.
- MIE=1, mie=32'h80, timer_irq=1, ex_pc=32'h200 -> next cycle redirect_valid=1, redirect_pc=32'h0001_0000; mepc=32'h200; mstatus=32'h0000_1880. Then MRET -> redirect_pc=32'h200, mstatus=32'h0000_1888.
- WFI at ex_pc=32'h300, MIE=1, mie bit11=1; ext_irq rises after 5 cycles -> wfi_stall=1 for those 5 cycles; then redirect_pc=32'h0001_0000, mepc=32'h304. Repeat with MIE=0 -> redirect_pc=32'h304, mepc unchanged.
- Write mcycle=32'hFFFF_FFFE, mcycleh=32'hFFFF_FFFF -> 2 cycles later mcycle/mcycleh both read 0. retire held 3 cycles -> minstret +3.
- rst_n pulsed low while in WFI_WAIT -> wfi_stall=0, redirect_valid=0, mstatus=32'h0000_1800 immediately (async).
